// File: rtl/stream_intv_delay.sv
// Multi-channel val/rdy interval-delay stage: per-channel 2-entry FIFO whose
// output transfers are spaced by a fixed or LFSR-derived gap.
module stream_intv_delay #(
   parameter int unsigned p_num_chan  = 2,
   parameter int unsigned p_msg_bits  = 32,
   parameter int unsigned p_intv_bits = 4,
   parameter logic [15:0] p_lfsr_seed = 16'hACE1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [1:0]                       cfg_mode,
   input  logic [p_intv_bits-1:0]           cfg_intv,
   input  logic [p_num_chan-1:0]            istream_val,
   output logic [p_num_chan-1:0]            istream_rdy,
   input  logic [p_num_chan*p_msg_bits-1:0] istream_msg,
   output logic [p_num_chan-1:0]            ostream_val,
   input  logic [p_num_chan-1:0]            ostream_rdy,
   output logic [p_num_chan*p_msg_bits-1:0] ostream_msg,
   output logic [p_num_chan*16-1:0]         xfer_count
);

   typedef enum logic [1:0] {
      MODE_PASS  = 2'd0,
      MODE_FIXED = 2'd1,
      MODE_RAND  = 2'd2,
      MODE_STALL = 2'd3
   } mode_e;

   mode_e mode;
   assign mode = mode_e'(cfg_mode);

   genvar c;
   generate
      for (c = 0; c < p_num_chan; c++) begin : g_chan
         localparam logic [15:0] seed_raw = p_lfsr_seed ^ 16'(c + 1);
         localparam logic [15:0] seed     = (seed_raw == 16'h0000) ? 16'h0001 : seed_raw;

         logic [p_msg_bits-1:0]  mem [2];
         logic                   head;
         logic [1:0]             cnt;
         logic [p_intv_bits-1:0] dcnt;
         logic [p_intv_bits-1:0] dcnt_reload;
         logic [p_intv_bits-1:0] rnd_val;
         logic [15:0]            lfsr;
         logic [15:0]            lfsr_nxt;
         logic [15:0]            xcnt;
         logic                   full;
         logic                   oval;
         logic                   push;
         logic                   pop;

         // Ready is gated by reset directly so it reads 0 throughout reset
         // and 1 as soon as reset is released.
         assign full           = (cnt == 2'd2);
         assign istream_rdy[c] = rst & ~full;
         assign oval           = (cnt != 2'd0) && (dcnt == '0) && (mode != MODE_STALL);
         assign push           = istream_val[c] & istream_rdy[c];
         assign pop            = oval & ostream_rdy[c];

         assign ostream_val[c]                          = oval;
         assign ostream_msg[c*p_msg_bits +: p_msg_bits] = mem[head];
         assign xfer_count[c*16 +: 16]                  = xcnt;

         // Galois form of x^16+x^14+x^13+x^11+1
         always_comb begin
            lfsr_nxt = {1'b0, lfsr[15:1]};
            if (lfsr[0]) lfsr_nxt = lfsr_nxt ^ 16'hB400;
         end

         // An all-ones interval means a modulus of 2^p_intv_bits, i.e. the raw bits.
         always_comb begin
            rnd_val     = '0;
            dcnt_reload = '0;
            if (&cfg_intv) rnd_val = lfsr[p_intv_bits-1:0];
            else           rnd_val = lfsr[p_intv_bits-1:0] % (cfg_intv + p_intv_bits'(1));
            case (mode)
               MODE_FIXED: dcnt_reload = cfg_intv;
               MODE_RAND:  dcnt_reload = rnd_val;
               default:    dcnt_reload = '0;
            endcase
         end

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               for (int unsigned i = 0; i < 2; i++) mem[i] <= '0;
               head <= 1'b0;
               cnt  <= 2'd0;
               dcnt <= '0;
               lfsr <= seed;
               xcnt <= '0;
            end else begin
               lfsr <= lfsr_nxt;
               if (push) mem[head ^ cnt[0]] <= istream_msg[c*p_msg_bits +: p_msg_bits];
               if (pop) begin
                  head <= ~head;
                  xcnt <= xcnt + 16'd1;
                  dcnt <= dcnt_reload;
               end else if (dcnt != '0) begin
                  dcnt <= dcnt - p_intv_bits'(1);
               end
               case ({push, pop})
                  2'b10:   cnt <= cnt + 2'd1;
                  2'b01:   cnt <= cnt - 2'd1;
                  default: cnt <= cnt;
               endcase
            end
         end
      end
   endgenerate

endmodule
